core_boot_ctrl: RTL
===================

// Module: core_boot_ctrl
// PURPOSE
//  Run controller for the single-cycle core. Receives a program as a byte stream,
//  writes it word by word into instruction memory, publishes last_pc, and then
//  enables the core. It detects halt (PC parked at last_pc), times out runaway
//  programs, and reports a cycle count. It sits between the host byte link and the
//  core/imem pair.
// PARAMETERS
//  IMEM_AW   10          imem word-address width; max program = 2**IMEM_AW words
//  CYC_W     32          width of cycle_cnt
//  MAX_CYC   1000000     RUN-cycle limit before timeout error
//  HALT_CNT  2           consecutive cycles core_pc==last_pc needed to declare halt
// PORTS
//  clk         in   1        clock; all flops on posedge
//  rst         in   1        async active-high reset
//  rx_valid    in   1        host byte valid
//  rx_data     in   8        host byte
//  rx_ready    out  1        byte accepted when rx_valid & rx_ready
//  abort       in   1        host abort request
//  clear       in   1        leave DONE/ERR, rearm for next program
//  imem_we     out  1        instruction-memory write strobe (1-cycle pulse)
//  imem_addr   out  IMEM_AW  word address of the write
//  imem_wdata  out  32       word written
//  core_run    out  1        core enable; high only in RUN
//  last_pc     out  32       N-1 zero-extended; drives the core's last_pc input
//  core_pc     in   32       core instr_addr (PC of the next instruction)
//  cycle_cnt   out  CYC_W    RUN cycles elapsed; saturates at all-ones
//  busy        out  1        high in LEN_HI, DATA, RUN
//  done        out  1        high in DONE
//  err         out  1        high in ERR
//  err_code    out  2        0 none, 1 bad length, 2 timeout, 3 abort
// BEHAVIOUR
//  Reset: state=LEN_LO; every output 0 (rx_ready=1 from the first post-reset cycle).
//   Reset asserted mid-operation clears imem_we and core_run immediately.
//  Frame: len[7:0], len[15:8], then N words of 4 bytes each, little-endian.
//  LEN_LO: rx_ready=1. On accept, latch len low byte -> LEN_HI.
//  LEN_HI: rx_ready=1. On accept, N={byte,lo}. N==0 or N>2**IMEM_AW -> ERR, code 1.
//   Otherwise last_pc<=N-1, word index=0, byte index=0 -> DATA.
//  DATA: rx_ready=1. Byte k of a word goes to bits [8k+7:8k]. On the 4th byte:
//   the next cycle has imem_we=1, imem_addr=index, imem_wdata=word; index increments.
//   The write of word N-1 goes to RUN on the cycle after its imem_we pulse.
//  RUN: rx_ready=0; core_run=1; cycle_cnt+1 per cycle, starting from 0.
//   halt counter increments while core_pc==last_pc and resets to 0 otherwise.
//   Halt counter reaching HALT_CNT -> DONE. cycle_cnt==MAX_CYC -> ERR, code 2.
//   If halt and timeout coincide, halt wins.
//  DONE/ERR: core_run=0; cycle_cnt, last_pc and err_code hold. clear -> LEN_LO, and
//   cycle_cnt, err_code, last_pc and counters are zeroed.
//  abort in LEN_HI/DATA/RUN -> ERR, code 3. Abort beats every other transition.
//   Abort in LEN_LO/DONE/ERR is ignored.
//  rx_ready=0 in RUN/DONE/ERR; bytes offered there are not consumed.
//  imem_we never asserts outside the DATA->write cycle, and never together with core_run.
// TESTING
//  1. Stream 02 00 | 13 00 00 00 | 6F 00 00 00 ->
//     imem_we pulses at addr 0 with 0x00000013, then at addr 1 with 0x0000006F.
//     last_pc=1, then core_run=1.
//  2. In RUN, drive core_pc=1 for 2 cycles -> done=1, core_run=0, cycle_cnt holds its value.
//  3. Length bytes 00 00 -> err=1, err_code=1, no imem_we. clear -> back to LEN_LO.
//  4. MAX_CYC=16, core_pc never equals last_pc -> err_code=2 after 16 RUN cycles.
//  5. abort after 2 data bytes -> ERR with code 3, no imem_we. Same abort in the
//     cycle halt is met -> err_code=3.
//  6. rst mid-DATA with rx_valid held high -> all outputs 0; restart with a
//     1-word frame loads correctly.

Source files
------------

// File: rtl/core_boot_ctrl.sv
// Boot/run controller: loads a length-prefixed byte stream into imem, runs the core,
// detects halt at last_pc, times out runaway programs and reports the cycle count.
module core_boot_ctrl #(
  parameter int IMEM_AW  = 10,
  parameter int CYC_W    = 32,
  parameter int MAX_CYC  = 1000000,
  parameter int HALT_CNT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               rx_ready,
  input  logic               abort,
  input  logic               clear,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               core_run,
  output logic [31:0]        last_pc,
  input  logic [31:0]        core_pc,
  output logic [CYC_W-1:0]   cycle_cnt,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code
);

  // state   | meaning
  // LEN_LO  | waiting for length low byte
  // LEN_HI  | waiting for length high byte, length checked on accept
  // DATA    | collecting program bytes, one imem write per 4 bytes
  // RUN     | core enabled, watching for halt and timeout
  // DONE    | program halted, results held until clear
  // ERR     | bad length / timeout / abort, held until clear
  typedef enum logic [2:0] {
    S_LEN_LO, S_LEN_HI, S_DATA, S_RUN, S_DONE, S_ERR
  } state_t;

  localparam int          HW        = $clog2(HALT_CNT + 1);
  localparam int unsigned MAX_WORDS = 1 << IMEM_AW;

  state_t             state;
  logic [7:0]         len_lo;
  logic [IMEM_AW-1:0] word_idx;
  logic [1:0]         byte_idx;
  logic [23:0]        word_buf;
  logic               last_wr;
  logic [HW-1:0]      halt_cnt;

  logic               accept;
  logic [15:0]        len_n;
  logic               len_bad;
  logic [CYC_W-1:0]   cyc_inc;
  logic [HW-1:0]      halt_nxt;
  logic               abort_hit;

  // rx_ready is gated by rst so nothing is accepted while reset is held
  assign rx_ready = ~rst & ((state == S_LEN_LO) | (state == S_LEN_HI) |
                            ((state == S_DATA) & ~last_wr));
  assign accept   = rx_valid & rx_ready;
  assign len_n    = {rx_data, len_lo};
  assign len_bad  = (len_n == 16'd0) || ({16'd0, len_n} > 32'(MAX_WORDS));
  assign cyc_inc  = (&cycle_cnt) ? cycle_cnt : cycle_cnt + 1'b1;
  assign halt_nxt = (core_pc == last_pc) ? halt_cnt + 1'b1 : '0;
  assign abort_hit = abort & ((state == S_LEN_HI) | (state == S_DATA) | (state == S_RUN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_LEN_LO;
      len_lo     <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
      last_wr    <= 1'b0;
      halt_cnt   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_run   <= 1'b0;
      last_pc    <= '0;
      cycle_cnt  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      imem_we <= 1'b0;
      if (abort_hit) begin
        state    <= S_ERR;
        err_code <= 2'd3;
        err      <= 1'b1;
        busy     <= 1'b0;
        core_run <= 1'b0;
        last_wr  <= 1'b0;
      end else begin
        case (state)
          S_LEN_LO: if (accept) begin
            len_lo <= rx_data;
            busy   <= 1'b1;
            state  <= S_LEN_HI;
          end
          S_LEN_HI: if (accept) begin
            if (len_bad) begin
              state    <= S_ERR;
              err_code <= 2'd1;
              err      <= 1'b1;
              busy     <= 1'b0;
            end else begin
              last_pc  <= {16'd0, len_n - 16'd1};
              word_idx <= '0;
              byte_idx <= '0;
              last_wr  <= 1'b0;
              state    <= S_DATA;
            end
          end
          S_DATA: begin
            if (last_wr) begin
              // final word's write strobe is out this cycle; core starts next
              last_wr   <= 1'b0;
              core_run  <= 1'b1;
              cycle_cnt <= '0;
              halt_cnt  <= '0;
              state     <= S_RUN;
            end else if (accept) begin
              byte_idx <= byte_idx + 2'd1;
              if (byte_idx == 2'd3) begin
                imem_we    <= 1'b1;
                imem_addr  <= word_idx;
                imem_wdata <= {rx_data, word_buf};
                word_idx   <= word_idx + 1'b1;
                if (word_idx == last_pc[IMEM_AW-1:0]) last_wr <= 1'b1;
              end else begin
                word_buf[8*byte_idx +: 8] <= rx_data;
              end
            end
          end
          S_RUN: begin
            cycle_cnt <= cyc_inc;
            halt_cnt  <= halt_nxt;
            if (halt_nxt == HW'(HALT_CNT)) begin
              state    <= S_DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              core_run <= 1'b0;
            end else if (cyc_inc == CYC_W'(MAX_CYC)) begin
              state    <= S_ERR;
              err_code <= 2'd2;
              err      <= 1'b1;
              busy     <= 1'b0;
              core_run <= 1'b0;
            end
          end
          S_DONE, S_ERR: if (clear) begin
            state     <= S_LEN_LO;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'd0;
            cycle_cnt <= '0;
            last_pc   <= '0;
            halt_cnt  <= '0;
            word_idx  <= '0;
            byte_idx  <= '0;
          end
          default: state <= S_LEN_LO;
        endcase
      end
    end
  end

endmodule
